mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store unit between the multicycle controller's MEM stage and a variable-latency data memory.
- Accepts one load/store request per transaction, decoded from funct3.
- Drives a req/ack memory handshake with byte enables, then returns sign- or zero-extended load data.
- Reports alignment and encoding faults and holds the controller in MEM via busy until done.

Parameters:
- MEM_AW, 9, memory word-address span in bits; mem_addr carries addr[MEM_AW-1:2] zero-padded.
- TIMEOUT_CYCLES, 16, maximum cycles waiting for mem_ack (used only with the optional feature).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  one-cycle request strobe from the controller; sampled only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  in  32  byte address; the ALU result.
- wdata  in  32  store data (rs2), LSB-aligned.
- busy  out  1  high from the accept cycle until done.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  extended load data; held until the next load completes.
- fault  out  1  asserted with done when the transaction was rejected.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable, qualified by mem_req.
- mem_addr  out  MEM_AW  word-aligned memory address.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  memory completion; one cycle.
- mem_rdata  in  32  memory read word; valid with mem_ack.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy, done, fault, mem_req and mem_we = 0; mem_be=0; mem_addr, mem_wdata and rdata = 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_valid=1 latches req_we, funct3, addr and wdata, and raises busy.
  - Legal request: next state ACCESS.
  - Illegal request: next state RESP with fault latched.
  - Illegal means: funct3 not in the supported set (store: only 000/001/010 legal); H with addr[0]≠0; W with addr[1:0]≠0.
- ACCESS:
  - mem_req=1, with mem_addr, mem_be, mem_we and mem_wdata stable until the ack.
  - On mem_ack, capture the extended load data into rdata (loads only); next state RESP.
  - If mem_ack arrives in the same cycle mem_req first rises, the access completes; the minimum legal path is 3 cycles (accept → ACCESS → RESP).
- RESP:
  - done=1 for one cycle; fault=1 with it if rejected; busy drops with done.
  - Next state IDLE. A req_valid arriving during RESP is ignored, and req_valid is ignored in ACCESS as well.
- Byte enables:
  - B: 4'b0001<<addr[1:0].
  - H: 4'b0011<<addr[1:0] (addr[1] selects).
  - W: 4'b1111.
- Store data replication:
  - B: {4{wdata[7:0]}}.
  - H: {2{wdata[15:0]}}.
  - W: wdata.
- Load extraction: select the byte/half by addr[1:0]. B/H sign-extend bit 7/15; BU/HU zero-extend.
- A rejected request issues no mem_req and leaves rdata unchanged.
- A stray mem_ack outside ACCESS is ignored.
- Reset mid-transaction aborts immediately: mem_req falls asynchronously and no done is produced.

Optional Feature:
- Macro: MEM_ACCESS_TIMEOUT_EN.
- When defined:
  - An ACCESS-state counter counts from 0.
  - If mem_ack has not arrived when the counter reaches TIMEOUT_CYCLES-1, mem_req drops and next state is RESP with fault=1; rdata is unchanged.
  - The counter clears on entry to ACCESS.
- When undefined: no counter; ACCESS waits indefinitely for mem_ack.

Decomposition:
- Shared package (riscv_pkg):
  - funct3 size encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - The state encoding localparams for IDLE, ACCESS and RESP.
  - OPCODE_LW/OPCODE_S_TYPE, which remain shared with the controller.
- One natural sub-module, mem_lane_align: purely combinational; produces mem_be, mem_wdata, the misalign flag and the extended load data from funct3, addr[1:0], wdata and mem_rdata.

Test Plan:
- LW from addr 0x00000010, memory word 0xDEADBEEF, mem_ack 2 cycles after mem_req → mem_addr=4, mem_be=1111, done one cycle after ack, rdata=0xDEADBEEF, fault=0.
- LB at addr 0x13, then LBU at addr 0x13, memory word 0x80FF7F01 → LB gives mem_be=1000 and rdata=0xFFFFFF80; LBU gives rdata=0x00000080.
- SH with wdata=0x1234ABCD at addr 0x06 → mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD, done after ack.
- LW at addr 0x02 → no mem_req, done+fault on the cycle after accept, rdata unchanged; an SB with funct3=011 also faults.
- Assert rst=0 during ACCESS → mem_req and busy go 0 immediately, no done pulse; a later request completes normally.
- With MEM_ACCESS_TIMEOUT_EN and TIMEOUT_CYCLES=16, hold mem_ack=0 → mem_req drops after 16 cycles, then done=1 and fault=1.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_pkg
//  Purpose  : funct3 size codes, load/store unit state encoding, shared opcodes
//  Revision : 1.0
// ============================================================================
package riscv_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int STATE_W = 2;
   localparam logic [STATE_W-1:0] IDLE   = 2'd0;
   localparam logic [STATE_W-1:0] ACCESS = 2'd1;
   localparam logic [STATE_W-1:0] RESP   = 2'd2;

   localparam logic [6:0] OPCODE_LW     = 7'b0000011;
   localparam logic [6:0] OPCODE_S_TYPE = 7'b0100011;

   // Unsigned sizes only exist for loads.
   function automatic logic f3_supported(input logic we, input logic [2:0] f3);
      case (f3)
         F3_B, F3_H, F3_W: return 1'b1;
         F3_BU, F3_HU:     return !we;
         default:          return 1'b0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module   : mem_lane_align
//  Purpose  : byte enables, store lane replication, misalign flag, load extend
//  Revision : 1.0
// ============================================================================
module mem_lane_align
   import riscv_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] mem_rdata,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   output logic        misalign,
   output logic [31:0] load_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = mem_rdata[{addr_lo, 3'b000} +: 8];
   assign w_half = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

   always_comb begin
      mem_be    = 4'b0000;
      mem_wdata = wdata;
      misalign  = 1'b0;
      load_data = mem_rdata;
      case (funct3)
         F3_B, F3_BU: begin
            mem_be    = 4'b0001 << addr_lo;
            mem_wdata = {4{wdata[7:0]}};
            load_data = (funct3 == F3_B) ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
         end
         F3_H, F3_HU: begin
            mem_be    = 4'b0011 << addr_lo;
            mem_wdata = {2{wdata[15:0]}};
            misalign  = addr_lo[0];
            load_data = (funct3 == F3_H) ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
         end
         F3_W: begin
            mem_be   = 4'b1111;
            misalign = |addr_lo;
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit
//  Purpose  : MEM-stage load/store unit with req/ack memory handshake.
//             Optional ACCESS timeout enabled by MEM_ACCESS_TIMEOUT_EN.
//  Revision : 1.0
// ============================================================================
module mem_access_unit
   import riscv_pkg::*;
#(
   parameter int MEM_AW         = 9,
   parameter int TIMEOUT_CYCLES = 16
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [2:0]        funct3,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic              busy,
   output logic              done,
   output logic [31:0]       rdata,
   output logic              fault,
   output logic              mem_req,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata
);

   logic [STATE_W-1:0] r_state, w_next;
   logic               r_we, r_fault;
   logic [2:0]         r_f3;
   logic [MEM_AW-1:0]  r_addr;
   logic [31:0]        r_wdata, r_rdata;

   logic [2:0]  w_f3;
   logic [1:0]  w_addr_lo;
   logic [3:0]  w_be;
   logic [31:0] w_load;
   logic        w_misalign, w_illegal, w_accept, w_timeout;
   logic        w_unused;

   // In IDLE the aligner looks at the incoming request so legality is known at accept.
   assign w_f3      = (r_state == IDLE) ? funct3    : r_f3;
   assign w_addr_lo = (r_state == IDLE) ? addr[1:0] : r_addr[1:0];

   mem_lane_align u_align (
      .funct3    (w_f3),
      .addr_lo   (w_addr_lo),
      .wdata     (r_wdata),
      .mem_rdata (mem_rdata),
      .mem_be    (w_be),
      .mem_wdata (mem_wdata),
      .misalign  (w_misalign),
      .load_data (w_load)
   );

   assign w_accept  = (r_state == IDLE) && req_valid;
   assign w_illegal = !f3_supported(req_we, funct3) || w_misalign;
   assign w_unused  = ^{addr[31:MEM_AW], TIMEOUT_CYCLES[0]};

`ifdef MEM_ACCESS_TIMEOUT_EN
   localparam int TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [TCNT_W-1:0] r_tcnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_tcnt <= '0;
      else if (r_state != ACCESS)
         r_tcnt <= '0;
      else
         r_tcnt <= r_tcnt + TCNT_W'(1);
   end

   assign w_timeout = (r_state == ACCESS) && !mem_ack &&
                      (r_tcnt == TCNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (req_valid) w_next = w_illegal ? RESP : ACCESS;
         ACCESS:  if (mem_ack || w_timeout) w_next = RESP;
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      busy    = 1'b0;
      done    = 1'b0;
      fault   = 1'b0;
      mem_req = 1'b0;
      mem_we  = 1'b0;
      mem_be  = 4'b0000;
      case (r_state)
         IDLE:    busy = req_valid;
         ACCESS: begin
            busy    = 1'b1;
            mem_req = 1'b1;
            mem_we  = r_we;
            mem_be  = w_be;
         end
         RESP: begin
            busy  = 1'b1;
            done  = 1'b1;
            fault = r_fault;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_we    <= 1'b0;
         r_f3    <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_fault <= 1'b0;
         r_rdata <= '0;
      end else begin
         if (w_accept) begin
            r_we    <= req_we;
            r_f3    <= funct3;
            r_addr  <= addr[MEM_AW-1:0];
            r_wdata <= wdata;
            r_fault <= w_illegal;
         end
         if (w_timeout)
            r_fault <= 1'b1;
         if ((r_state == ACCESS) && mem_ack && !r_we)
            r_rdata <= w_load;
      end
   end

   assign mem_addr = {2'b00, r_addr[MEM_AW-1:2]};
   assign rdata    = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_unit
//  Purpose  : directed table, hand sequences and randomized model checks
//  Revision : 1.0
// ============================================================================
module tb_mem_access_unit;

   localparam int MEM_AW = 9;
   localparam int TOUT   = 16;

   logic              clk, rst, req_valid, req_we, mem_ack;
   logic [2:0]        funct3;
   logic [31:0]       addr, wdata, mem_rdata, rdata, mem_wdata;
   logic              busy, done, fault, mem_req, mem_we;
   logic [MEM_AW-1:0] mem_addr;
   logic [3:0]        mem_be;

   int          n_pass = 0;
   int          n_tot  = 0;
   logic [31:0] exp_rdata = 32'h0;

   mem_access_unit #(.MEM_AW(MEM_AW), .TIMEOUT_CYCLES(TOUT)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
      .funct3(funct3), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
      .rdata(rdata), .fault(fault), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] a, wd, mw;
      int          lat;
      logic        flt;
      logic [8:0]  e_addr;
      logic [3:0]  e_be;
      logic [31:0] e_wd, e_rd;
   } vec_t;

   vec_t tbl[14];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act !== exp)
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      else
         n_pass++;
   endtask

   // Reference model: access size from funct3, alignment by modulo, extension by arithmetic.
   function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] mw,
                                 output logic flt, output logic [3:0] be,
                                 output logic [31:0] wrep, output logic [31:0] ld);
      int     size;
      bit     sgn, ok;
      longint v;
      ok = 1; sgn = 0; size = 1;
      case (f3)
         3'd0: begin size = 1; sgn = 1; end
         3'd1: begin size = 2; sgn = 1; end
         3'd2: begin size = 4; sgn = 0; end
         3'd4: begin size = 1; sgn = 0; end
         3'd5: begin size = 2; sgn = 0; end
         default: ok = 0;
      endcase
      if (we && f3 > 3'd2) ok = 0;
      flt  = !ok || ((a % size) != 0);
      be   = 4'(((1 << size) - 1) << (a % 4));
      wrep = (size == 1) ? wd[7:0] * 32'h01010101 :
             (size == 2) ? wd[15:0] * 32'h00010001 : wd;
      v = (longint'(mw) >> (8 * (a % 4))) & ((64'd1 << (8 * size)) - 1);
      if (sgn && v >= (64'd1 << (8 * size - 1))) v = v - (64'd1 << (8 * size));
      ld = v[31:0];
   endfunction

   task automatic run_txn(input string nm, input logic we_i, input logic [2:0] f3_i,
                          input logic [31:0] a_i, input logic [31:0] wd_i, input logic [31:0] mw_i,
                          input int lat_i, input logic e_flt, input logic [8:0] e_addr,
                          input logic [3:0] e_be, input logic [31:0] e_wd, input logic [31:0] e_rd);
      int   cyc;
      logic bad;
      @(negedge clk);
      req_valid = 1'b1; req_we = we_i; funct3 = f3_i; addr = a_i; wdata = wd_i;
      @(negedge clk);
      req_valid = 1'b0; req_we = 1'($urandom); funct3 = 3'($urandom);
      addr = $urandom; wdata = $urandom;
      if (e_flt) begin
         check({nm, "_flt_req_done_fault"}, {mem_req, done, fault}, 3'b011);
         check({nm, "_flt_rdata"}, rdata, e_rd);
      end else begin
         check({nm, "_req_busy_done"}, {mem_req, busy, done}, 3'b110);
         check({nm, "_mem_addr"}, mem_addr, e_addr);
         check({nm, "_mem_be"}, mem_be, e_be);
         check({nm, "_mem_we"}, mem_we, we_i);
         if (we_i) check({nm, "_mem_wdata"}, mem_wdata, e_wd);
         cyc = 0; bad = 0;
         while (mem_req && cyc < 64) begin
            if (mem_addr !== e_addr || mem_be !== e_be || mem_we !== we_i || done !== 1'b0 ||
                (we_i && mem_wdata !== e_wd)) bad = 1;
            if (cyc == lat_i) begin mem_ack = 1'b1; mem_rdata = mw_i; end
            @(negedge clk);
            mem_ack = 1'b0; mem_rdata = $urandom;
            cyc++;
         end
         check({nm, "_stable"}, bad, 1'b0);
         check({nm, "_req_cycles"}, cyc, lat_i + 1);
         check({nm, "_done_fault"}, {done, fault}, 2'b10);
         check({nm, "_rdata"}, rdata, e_rd);
      end
      @(negedge clk);
      check({nm, "_idle_done_busy"}, {done, busy, mem_req}, 3'b000);
   endtask

   initial begin
      logic        flt, rdone, rbad;
      logic [3:0]  be;
      logic [31:0] wrep, ld, a, e_rd;
      int          cyc;

      tbl[0]  = '{1'b0, 3'b010, 32'h10,  32'h0,      32'hDEADBEEF, 2, 1'b0, 9'd4,  4'hF, 32'h0,      32'hDEADBEEF};
      tbl[1]  = '{1'b0, 3'b000, 32'h13,  32'h0,      32'h80FF7F01, 1, 1'b0, 9'd4,  4'h8, 32'h0,      32'hFFFFFF80};
      tbl[2]  = '{1'b0, 3'b100, 32'h13,  32'h0,      32'h80FF7F01, 0, 1'b0, 9'd4,  4'h8, 32'h0,      32'h00000080};
      tbl[3]  = '{1'b1, 3'b001, 32'h06,  32'h1234ABCD, 32'h0,      1, 1'b0, 9'd1,  4'hC, 32'hABCDABCD, 32'h00000080};
      tbl[4]  = '{1'b0, 3'b010, 32'h02,  32'h0,      32'h0,        0, 1'b1, 9'd0,  4'h0, 32'h0,      32'h00000080};
      tbl[5]  = '{1'b1, 3'b011, 32'h00,  32'h55,     32'h0,        0, 1'b1, 9'd0,  4'h0, 32'h0,      32'h00000080};
      tbl[6]  = '{1'b0, 3'b001, 32'h02,  32'h0,      32'h80FF7F01, 0, 1'b0, 9'd0,  4'hC, 32'h0,      32'hFFFF80FF};
      tbl[7]  = '{1'b0, 3'b101, 32'h00,  32'h0,      32'h80FF7F01, 3, 1'b0, 9'd0,  4'h3, 32'h0,      32'h00007F01};
      tbl[8]  = '{1'b1, 3'b010, 32'h0C,  32'hCAFEF00D, 32'h0,      3, 1'b0, 9'd3,  4'hF, 32'hCAFEF00D, 32'h00007F01};
      tbl[9]  = '{1'b0, 3'b001, 32'h01,  32'h0,      32'h0,        0, 1'b1, 9'd0,  4'h0, 32'h0,      32'h00007F01};
      tbl[10] = '{1'b0, 3'b110, 32'h00,  32'h0,      32'h0,        0, 1'b1, 9'd0,  4'h0, 32'h0,      32'h00007F01};
      tbl[11] = '{1'b1, 3'b000, 32'h01,  32'h000000A5, 32'h0,      0, 1'b0, 9'd0,  4'h2, 32'hA5A5A5A5, 32'h00007F01};
      tbl[12] = '{1'b1, 3'b100, 32'h00,  32'h0,      32'h0,        0, 1'b1, 9'd0,  4'h0, 32'h0,      32'h00007F01};
      tbl[13] = '{1'b0, 3'b000, 32'h1FD, 32'h0,      32'h12345678, 1, 1'b0, 9'h7F, 4'h2, 32'h0,      32'h00000056};

      rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; funct3 = 3'd0;
      addr = 32'h0; wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
      repeat (2) @(negedge clk);
      check("reset_ctl", {busy, done, fault, mem_req, mem_we}, 5'b0);
      check("reset_be", mem_be, 4'h0);
      check("reset_addr", mem_addr, 9'h0);
      check("reset_wdata", mem_wdata, 32'h0);
      check("reset_rdata", rdata, 32'h0);
      rst = 1'b1;

      for (int i = 0; i < 14; i++) begin
         run_txn($sformatf("tbl%0d", i), tbl[i].we, tbl[i].f3, tbl[i].a, tbl[i].wd, tbl[i].mw,
                 tbl[i].lat, tbl[i].flt, tbl[i].e_addr, tbl[i].e_be, tbl[i].e_wd, tbl[i].e_rd);
         exp_rdata = tbl[i].e_rd;
      end

      // Stray ack while idle must not complete anything or touch rdata.
      @(negedge clk);
      mem_ack = 1'b1; mem_rdata = 32'hA5A55A5A;
      @(negedge clk);
      mem_ack = 1'b0;
      check("stray_ack_ctl", {done, mem_req, busy}, 3'b000);
      check("stray_ack_rdata", rdata, exp_rdata);

      // A request strobe held through ACCESS and RESP is ignored.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; funct3 = 3'b010; addr = 32'h20;
      @(negedge clk);
      req_we = 1'b1; addr = 32'h44; wdata = 32'h0BADF00D;
      cyc = 0;
      while (mem_req && cyc < 64) begin
         if (cyc == 2) begin mem_ack = 1'b1; mem_rdata = 32'h13579BDF; end
         @(negedge clk);
         mem_ack = 1'b0;
         cyc++;
      end
      check("ignore_req_done", done, 1'b1);
      req_valid = 1'b0;
      exp_rdata = 32'h13579BDF;
      check("ignore_req_rdata", rdata, exp_rdata);
      rbad = 0;
      repeat (3) begin
         @(negedge clk);
         if (mem_req || done) rbad = 1;
      end
      check("ignore_req_no_second", rbad, 1'b0);

      // Reset in the middle of ACCESS aborts without a done pulse.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; funct3 = 3'b010; addr = 32'h40;
      @(negedge clk);
      req_valid = 1'b0;
      check("abort_in_access", mem_req, 1'b1);
      rst = 1'b0;
      #1;
      check("abort_async_req_busy", {mem_req, busy}, 2'b00);
      exp_rdata = 32'h0;
      check("abort_rdata_cleared", rdata, exp_rdata);
      @(negedge clk);
      rst = 1'b1;
      rdone = 0;
      repeat (3) begin
         @(negedge clk);
         if (done || mem_req) rdone = 1;
      end
      check("abort_no_done", rdone, 1'b0);
      run_txn("after_abort", 1'b0, 3'b010, 32'h40, 32'h0, 32'h600DCAFE, 1, 1'b0,
              9'h10, 4'hF, 32'h0, 32'h600DCAFE);
      exp_rdata = 32'h600DCAFE;

      for (int i = 0; i < 40; i++) begin
         logic       we;
         logic [2:0] f3;
         logic [31:0] wd, mw;
         we = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         wd = $urandom; mw = $urandom;
         model(we, f3, a, wd, mw, flt, be, wrep, ld);
         e_rd = (!flt && !we) ? ld : exp_rdata;
         run_txn($sformatf("rnd%0d", i), we, f3, a, wd, mw, $urandom_range(0, 4), flt,
                 9'((a >> 2) & 32'h7F), be, wrep, e_rd);
         exp_rdata = e_rd;
      end

`ifdef MEM_ACCESS_TIMEOUT_EN
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; funct3 = 3'b010; addr = 32'h80;
      @(negedge clk);
      req_valid = 1'b0;
      cyc = 0;
      while (mem_req && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check("timeout_req_cycles", cyc, TOUT);
      check("timeout_done_fault", {done, fault}, 2'b11);
      check("timeout_rdata", rdata, exp_rdata);
      @(negedge clk);
`endif

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
`default_nettype wire
